// File: rtl/enduro_pkg.sv
// Shared types and default constants for the enduro FIFO reset/crossing logic.
package enduro_pkg;

    typedef enum logic [1:0] {
        RS_HOLD     = 2'd0,
        RS_WAIT_DST = 2'd1,
        RS_READY    = 2'd2
    } reset_seq_state_e;

    localparam int unsigned ENDURO_HOLD_CYCLES    = 16;
    localparam int unsigned ENDURO_SYNC_STAGES    = 3;
    localparam int unsigned ENDURO_TIMEOUT_CYCLES = 1024;

    function automatic int unsigned enduro_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/enduro_reset_seq_if.sv
// Control/status bundle between the reset sequencer and its surroundings.
interface enduro_reset_seq_if;

    logic soft_reset_req;
    logic dst_ready_async;
    logic reset_out_n;
    logic fifo_ready;
    logic timeout_err;

    modport master (
        output soft_reset_req,
        output dst_ready_async,
        input  reset_out_n,
        input  fifo_ready,
        input  timeout_err
    );

    modport slave (
        input  soft_reset_req,
        input  dst_ready_async,
        output reset_out_n,
        output fifo_ready,
        output timeout_err
    );

endinterface

// File: rtl/enduro_bit_sync.sv
// Single-bit multi-flop synchronizer, asynchronously cleared to 0.
module enduro_bit_sync
    import enduro_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = ENDURO_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // shift the asynchronous input one stage deeper each edge
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // synchronizer flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/enduro_reset_seq.sv
// Source-domain reset sequencer: stretches the FIFO source reset, then waits
// for the synchronized destination acknowledge before flagging the FIFO ready.
module enduro_reset_seq
    import enduro_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = ENDURO_HOLD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = ENDURO_TIMEOUT_CYCLES,
    parameter int unsigned SYNC_STAGES    = ENDURO_SYNC_STAGES
) (
    input  logic                src_clk,
    input  logic                src_reset_n,
    enduro_reset_seq_if.slave   bus
);

    localparam int unsigned     CNT_W     = $clog2(enduro_max(HOLD_CYCLES, TIMEOUT_CYCLES));
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    reset_seq_state_e  state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              reset_out_n_q, reset_out_n_d;
    logic              fifo_ready_q, fifo_ready_d;
    logic              timeout_err_q, timeout_err_d;
    logic              dst_ready_s;

    // bring the destination acknowledge into src_clk; soft reset leaves it alone
    enduro_bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (src_clk),
        .rst_n (src_reset_n),
        .d     (bus.dst_ready_async),
        .q     (dst_ready_s)
    );

    // state, counter and output registers
    always_ff @(posedge src_clk or negedge src_reset_n) begin
        if (!src_reset_n) begin
            state_q       <= RS_HOLD;
            cnt_q         <= '0;
            reset_out_n_q <= 1'b0;
            fifo_ready_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reset_out_n_q <= reset_out_n_d;
            fifo_ready_q  <= fifo_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // next state and counter; soft reset overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.soft_reset_req) begin
            state_d = RS_HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RS_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = RS_WAIT_DST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RS_WAIT_DST: begin
                    if (dst_ready_s) begin
                        state_d = RS_READY;
                        cnt_d   = '0;
                    end else if (cnt_q != TO_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RS_READY: begin
                    if (!dst_ready_s) begin
                        state_d = RS_WAIT_DST;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = RS_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // next values of the registered outputs
    always_comb begin
        reset_out_n_d = reset_out_n_q;
        fifo_ready_d  = fifo_ready_q;
        timeout_err_d = timeout_err_q;
        if (bus.soft_reset_req) begin
            reset_out_n_d = 1'b0;
            fifo_ready_d  = 1'b0;
            timeout_err_d = 1'b0;
        end else begin
            case (state_q)
                RS_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        reset_out_n_d = 1'b1;
                    end
                end
                RS_WAIT_DST: begin
                    if (dst_ready_s) begin
                        fifo_ready_d = 1'b1;
                    end else if (cnt_q == TO_LAST) begin
                        timeout_err_d = 1'b1;
                    end
                end
                RS_READY: begin
                    if (!dst_ready_s) begin
                        fifo_ready_d = 1'b0;
                    end
                end
                default: begin
                    reset_out_n_d = 1'b0;
                    fifo_ready_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.reset_out_n = reset_out_n_q;
    assign bus.fifo_ready  = fifo_ready_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_enduro_reset_seq.sv
// Directed bench for enduro_reset_seq: one default instance (a) and one short
// instance (b: HOLD=4, SYNC=3, TIMEOUT=8) sharing clock and reset.
module tb_enduro_reset_seq;

    logic src_clk = 1'b0;
    logic src_reset_n;

    enduro_reset_seq_if ifa ();
    enduro_reset_seq_if ifb ();

    enduro_reset_seq dut_a (
        .src_clk     (src_clk),
        .src_reset_n (src_reset_n),
        .bus         (ifa.slave)
    );

    enduro_reset_seq #(
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (8),
        .SYNC_STAGES    (3)
    ) dut_b (
        .src_clk     (src_clk),
        .src_reset_n (src_reset_n),
        .bus         (ifb.slave)
    );

    always #5 src_clk = ~src_clk;

    // expected {reset_out_n, fifo_ready, timeout_err} at a given edge number
    typedef struct {
        int         cyc;
        bit         sel_b;
        logic [2:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int c, input bit sel_b, input logic [2:0] exp, input string tag);
        exp_t e;
        e.cyc   = c;
        e.sel_b = sel_b;
        e.exp   = exp;
        e.tag   = $sformatf("%s_%s@%0d", tag, sel_b ? "b" : "a", c);
        sb.push_back(e);
    endtask

    task automatic chk(input bit sel_b, input logic [2:0] exp, input string tag);
        logic [2:0] obs;
        obs = sel_b ? {ifb.reset_out_n, ifb.fifo_ready, ifb.timeout_err}
                    : {ifa.reset_out_n, ifa.fifo_ready, ifa.timeout_err};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {rst_n,rdy,err}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int i;
        @(posedge src_clk);
        #1;
        cyc++;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].sel_b, sb[i].exp, sb[i].tag);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic drain_check(input string tag);
        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL %s: observed pending=%0d expected=0", tag, sb.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        src_reset_n         = 1'b0;
        ifa.soft_reset_req  = 1'b0;
        ifb.soft_reset_req  = 1'b0;
        ifa.dst_ready_async = 1'b1;
        ifb.dst_ready_async = 1'b0;
        cyc = 0;

        repeat (3) @(posedge src_clk);
        #1;
        chk(1'b0, 3'b000, "reset_a");
        chk(1'b1, 3'b000, "reset_b");

        // phase 1: power-up release, next edge is edge 1
        #3;
        src_reset_n = 1'b1;
        cyc = 0;

        push(15, 1'b0, 3'b000, "hold");
        push(16, 1'b0, 3'b100, "rel");
        push(17, 1'b0, 3'b110, "ready");
        push(3,  1'b1, 3'b000, "hold");
        push(4,  1'b1, 3'b100, "rel");
        push(11, 1'b1, 3'b100, "pre_to");
        push(12, 1'b1, 3'b101, "timeout");
        push(14, 1'b1, 3'b101, "to_sat");

        run_to(14);
        ifb.dst_ready_async = 1'b1;
        push(17, 1'b1, 3'b101, "late_ack_wait");
        push(18, 1'b1, 3'b111, "late_ack");

        run_to(20);
        ifa.dst_ready_async = 1'b0;
        push(23, 1'b0, 3'b110, "loss_wait");
        push(24, 1'b0, 3'b100, "loss");

        run_to(26);
        ifa.dst_ready_async = 1'b1;
        push(29, 1'b0, 3'b100, "reack_wait");
        push(30, 1'b0, 3'b110, "reack");

        run_to(32);
        ifa.soft_reset_req = 1'b1;
        ifb.soft_reset_req = 1'b1;
        push(33, 1'b0, 3'b000, "soft1");
        push(33, 1'b1, 3'b000, "soft1");
        push(35, 1'b0, 3'b000, "soft3");
        push(35, 1'b1, 3'b000, "soft3");
        run_to(35);
        ifa.soft_reset_req = 1'b0;
        ifb.soft_reset_req = 1'b0;
        push(38, 1'b1, 3'b000, "shold");
        push(39, 1'b1, 3'b100, "srel");
        push(40, 1'b1, 3'b110, "sready");
        push(50, 1'b0, 3'b000, "shold");
        push(51, 1'b0, 3'b100, "srel");
        push(52, 1'b0, 3'b110, "sready");

        run_to(55);
        drain_check("phase1_drain");

        // phase 2: a in HOLD, b in WAIT_DST, then async reset pulse
        ifa.soft_reset_req  = 1'b1;
        ifb.soft_reset_req  = 1'b1;
        ifb.dst_ready_async = 1'b0;
        push(56, 1'b0, 3'b000, "soft2");
        push(56, 1'b1, 3'b000, "soft2");
        run_to(56);
        ifa.soft_reset_req = 1'b0;
        ifb.soft_reset_req = 1'b0;
        push(59, 1'b1, 3'b000, "hold2");
        push(60, 1'b1, 3'b100, "rel2");
        push(63, 1'b1, 3'b100, "wait2");
        push(63, 1'b0, 3'b000, "hold2");
        run_to(63);

        #3;
        src_reset_n = 1'b0;
        #1;
        chk(1'b0, 3'b000, "async_hold_a");
        chk(1'b1, 3'b000, "async_wait_b");
        repeat (2) @(posedge src_clk);
        #1;
        chk(1'b1, 3'b000, "in_reset_b");

        // phase 3: full restart; b acknowledge rises before edge 10
        #3;
        src_reset_n = 1'b1;
        cyc = 0;
        push(15, 1'b0, 3'b000, "r_hold");
        push(16, 1'b0, 3'b100, "r_rel");
        push(17, 1'b0, 3'b110, "r_ready");
        push(3,  1'b1, 3'b000, "r_hold");
        push(4,  1'b1, 3'b100, "r_rel");
        push(11, 1'b1, 3'b100, "r_wait");
        push(12, 1'b1, 3'b101, "r_to");
        push(13, 1'b1, 3'b111, "r_ready");

        run_to(9);
        ifb.dst_ready_async = 1'b1;
        run_to(20);
        drain_check("phase3_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enduro_reset_seq.md
# enduro_reset_seq

Source-domain reset sequencer for the enduro FIFO. It stretches and synchronously releases the source-side FIFO reset, then waits for the destination-domain "reset released" indication to return across the clock boundary before it declares the FIFO usable. It is the source-side partner of the destination-side signal synchronizer: it drives the reset that synchronizer samples, and it consumes that synchronizer's output as an asynchronous acknowledge.

## Interface
- HOLD_CYCLES, 16: src_clk edges that reset_out_n stays low after reset release or a soft reset; ≥2.
- TIMEOUT_CYCLES, 1024: WAIT_DST edges without acknowledge before timeout_err sets; ≥2.
- SYNC_STAGES, 3: flop depth of the acknowledge synchronizer; ≥2.
- src_clk  input  1  source-domain clock; the only clock.
- src_reset_n  input  1  asynchronous, active-low reset.
- soft_reset_req  input  1  synchronous level request to restart the sequence.
- dst_ready_async  input  1  destination reset-released flag; asynchronous to src_clk.
- reset_out_n  output  1  registered, active-low FIFO source-side reset.
- fifo_ready  output  1  registered; high when both domains are out of reset.
- timeout_err  output  1  registered, sticky; the acknowledge did not arrive in time.

## Operation
- Under src_reset_n=0: state RS_HOLD, counter 0, synchronizer flops 0, reset_out_n=0, fifo_ready=0, timeout_err=0.
- dst_ready_async passes through SYNC_STAGES flops; the last stage is dst_ready_s. Only src_reset_n resets the synchronizer. A soft reset does not.
- RS_HOLD:
  - counter increments every edge.
  - When counter==HOLD_CYCLES-1: go to RS_WAIT_DST, clear counter, set reset_out_n←1.
- RS_WAIT_DST:
  - If dst_ready_s=1: go to RS_READY, set fifo_ready←1, clear counter.
  - Otherwise counter increments, saturating at TIMEOUT_CYCLES-1. When counter==TIMEOUT_CYCLES-1, set timeout_err←1 and stay in RS_WAIT_DST.
  - A later acknowledge still moves the block to RS_READY. timeout_err stays set.
- RS_READY:
  - If dst_ready_s=0: go to RS_WAIT_DST, set fifo_ready←0, clear counter. reset_out_n stays 1.
- soft_reset_req=1 in any state has priority over every other transition. On the next edge: state RS_HOLD, counter 0, reset_out_n←0, fifo_ready←0, timeout_err←0.
- While soft_reset_req is held high, the counter stays at 0. The HOLD count starts on the first edge after the request drops.
- Counter width is $clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES)). Compare values are cast to that width, and the counter never wraps.

## Timing
- Edge 1 is the first src_clk rising edge after src_reset_n deasserts.
- reset_out_n is high after edge HOLD_CYCLES.
- Assertion of src_reset_n is asynchronous: all outputs go to reset values immediately, mid-sequence included. Release is synchronous through the state machine.
- If dst_ready_async is already high in reset, the acknowledge reaches dst_ready_s at edge SYNC_STAGES.
  - fifo_ready rises at edge max(HOLD_CYCLES, SYNC_STAGES)+1.
  - The block always spends at least one edge in RS_WAIT_DST.
- In RS_WAIT_DST, a rise on dst_ready_async before edge k gives fifo_ready=1 after edge k+SYNC_STAGES.
- In RS_READY, a fall of dst_ready_async gives the same SYNC_STAGES+1 latency to fifo_ready=0.
- timeout_err rises on the TIMEOUT_CYCLES-th edge spent in RS_WAIT_DST without an acknowledge.
- If soft_reset_req and dst_ready_s both change on the same edge, soft reset wins.
- No output toggles combinationally from any input.

## Structure
- enduro_pkg holds:
  - typedef enum logic [1:0] reset_seq_state_e {RS_HOLD, RS_WAIT_DST, RS_READY}.
  - Default constants ENDURO_HOLD_CYCLES and ENDURO_SYNC_STAGES, shared with the FIFO top.
- Sub-module enduro_bit_sync: SYNC_STAGES-deep single-bit flop chain with asynchronous active-low reset to 0. It is reused later for other single-bit crossings.
- Sequencer FSM, counter and output registers live in enduro_reset_seq.

## Test plan
- Power-up, dst_ready_async=1, defaults → reset_out_n=1 after edge 16, fifo_ready=1 after edge 17, timeout_err=0.
- HOLD_CYCLES=4, SYNC_STAGES=3, dst_ready_async rises at edge 10 → reset_out_n=1 after edge 4, fifo_ready=1 after edge 13.
- TIMEOUT_CYCLES=8, dst_ready_async held 0 → timeout_err=1 after the 8th RS_WAIT_DST edge. A later acknowledge gives fifo_ready=1 with timeout_err still 1.
- Soft reset while in RS_READY:
  - soft_reset_req high for 3 edges → reset_out_n=0 and fifo_ready=0 after the first edge, timeout_err cleared.
  - reset_out_n=1 again HOLD_CYCLES edges after the request drops.
- Ready loss: dst_ready_async falls while in RS_READY → fifo_ready=0 after SYNC_STAGES+1 edges, reset_out_n stays 1. It rises again on re-acknowledge.
- src_reset_n pulsed low mid-RS_HOLD and mid-RS_WAIT_DST → outputs go to 0 asynchronously, then the full sequence restarts from edge 1.
